// File: rtl/inst_rom_resp.sv
// Instruction-fetch responder: synchronous instruction memory with a loader
// write port, configurable wait states, stall back-pressure and fault flagging.
module inst_rom_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           pc,
    output logic                  stall,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  fault,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [31:0]           ld_data
);
    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [2:0]  WS       = 3'(WAIT_STATES);
    localparam bit          HAS_WAIT = (WAIT_STATES > 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                r_state, w_next_state;
    logic [2:0]            r_cnt, w_next_cnt;
    logic [31:0]           r_pc, w_next_pc;
    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_inst;
    logic                  r_valid;
    logic                  r_fault;

    logic                  w_fire;
    logic                  w_stall;
    logic [31:0]           w_fetch_pc;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_fault;
    logic [ADDR_WIDTH-1:0] w_word;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_pc    = r_pc;
        w_fire       = 1'b0;
        w_stall      = 1'b0;
        w_fetch_pc   = pc;
        unique case (r_state)
            IDLE: begin
                if (ce) begin
                    if (HAS_WAIT) begin
                        w_next_state = BUSY;
                        w_next_cnt   = WS;
                        w_next_pc    = pc;
                        w_stall      = 1'b1;
                    end else begin
                        w_fire = 1'b1;
                    end
                end
            end
            BUSY: begin
                // ce/pc are ignored here; the latched address is fetched.
                w_fetch_pc = r_pc;
                w_next_cnt = r_cnt - 3'd1;
                w_stall    = (r_cnt > 3'd1);
                if (r_cnt == 3'd1) begin
                    w_fire       = 1'b1;
                    w_next_state = IDLE;
                end
            end
        endcase
    end

    assign w_misaligned   = |w_fetch_pc[1:0];
    assign w_out_of_range = |(w_fetch_pc >> (ADDR_WIDTH + 2));
    assign w_fault        = w_misaligned | w_out_of_range;
    assign w_word         = w_fetch_pc[ADDR_WIDTH+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pc    <= '0;
            r_inst  <= '0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_pc    <= w_next_pc;
            r_valid <= w_fire;
            r_fault <= w_fire & w_fault;
            r_inst  <= (w_fire && !w_fault) ? r_mem[w_word] : '0;
        end
    end

    // Loader writes share the edge with the fetch read, so a colliding fetch sees old data.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    assign stall      = w_stall & ~rst;
    assign inst       = r_inst;
    assign inst_valid = r_valid;
    assign fault      = r_fault;
endmodule

// File: tb/tb_inst_rom_resp.sv
// Bench for inst_rom_resp: three instances (0, 2 and 3 wait states) checked
// against a cycle-timestamp reference model plus directed scenarios.
module tb_inst_rom_resp;
    localparam int AW = 10;
    localparam int WS [3] = '{0, 2, 3};

    logic          clk = 1'b0;
    logic          rst;
    logic          ce_v    [3];
    logic [31:0]   pc_v    [3];
    logic          stall_v [3];
    logic [31:0]   inst_v  [3];
    logic          valid_v [3];
    logic          fault_v [3];
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] pat [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    always #5 clk = ~clk;

    inst_rom_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_w0 (
        .clk(clk), .rst(rst), .ce(ce_v[0]), .pc(pc_v[0]), .stall(stall_v[0]),
        .inst(inst_v[0]), .inst_valid(valid_v[0]), .fault(fault_v[0]),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
    inst_rom_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) u_w2 (
        .clk(clk), .rst(rst), .ce(ce_v[1]), .pc(pc_v[1]), .stall(stall_v[1]),
        .inst(inst_v[1]), .inst_valid(valid_v[1]), .fault(fault_v[1]),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
    inst_rom_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) u_w3 (
        .clk(clk), .rst(rst), .ce(ce_v[2]), .pc(pc_v[2]), .stall(stall_v[2]),
        .inst(inst_v[2]), .inst_valid(valid_v[2]), .fault(fault_v[2]),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

    // Reference model: a request accepted in cycle N completes with the memory
    // contents seen at the end of cycle N+W; the instance is busy until then.
    int unsigned cyc = 0;
    bit          pend     [3] = '{0, 0, 0};
    int unsigned last_acc [3] = '{0, 0, 0};
    logic [31:0] acc_pc   [3];
    logic        m_valid  [3] = '{0, 0, 0};
    logic        m_fault  [3] = '{0, 0, 0};
    logic [31:0] m_inst   [3] = '{0, 0, 0};
    logic [31:0] m_mem    [1024];

    function automatic logic is_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd4096);
    endfunction

    function automatic logic [31:0] resp_inst(input logic [31:0] a);
        if (is_fault(a)) return 32'h0;
        return m_mem[a / 4];
    endfunction

    function automatic logic exp_stall(input int k);
        if (rst) return 1'b0;
        if (pend[k]) return cyc < last_acc[k] + WS[k];
        return ce_v[k] && (WS[k] > 0);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                pend[k]    <= 1'b0;
                m_valid[k] <= 1'b0;
                m_fault[k] <= 1'b0;
                m_inst[k]  <= '0;
            end else if (pend[k] && cyc == last_acc[k] + WS[k]) begin
                pend[k]    <= 1'b0;
                m_valid[k] <= 1'b1;
                m_fault[k] <= is_fault(acc_pc[k]);
                m_inst[k]  <= resp_inst(acc_pc[k]);
            end else if (!pend[k] && ce_v[k] && WS[k] == 0) begin
                m_valid[k] <= 1'b1;
                m_fault[k] <= is_fault(pc_v[k]);
                m_inst[k]  <= resp_inst(pc_v[k]);
            end else begin
                if (!pend[k] && ce_v[k]) begin
                    pend[k]     <= 1'b1;
                    last_acc[k] <= cyc;
                    acc_pc[k]   <= pc_v[k];
                end
                m_valid[k] <= 1'b0;
                m_fault[k] <= 1'b0;
                m_inst[k]  <= '0;
            end
        end
        if (ld_we) m_mem[ld_addr] <= ld_data;
        cyc <= cyc + 1;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        ld_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ce_v[k] = 1'b1;
            pc_v[k] = 32'h8;
        end
        step;
        step;
        settle;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (stall_v[k] !== 1'b0) begin n_err++; $display("FAIL reset_stall k=%0d got=%b exp=0", k, stall_v[k]); end
            n_cmp++; if (valid_v[k] !== 1'b0) begin n_err++; $display("FAIL reset_valid k=%0d got=%b exp=0", k, valid_v[k]); end
            n_cmp++; if (fault_v[k] !== 1'b0) begin n_err++; $display("FAIL reset_fault k=%0d got=%b exp=0", k, fault_v[k]); end
            n_cmp++; if (inst_v[k] !== 32'h0) begin n_err++; $display("FAIL reset_inst k=%0d got=%h exp=0", k, inst_v[k]); end
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) ce_v[k] = 1'b0;
        step;
    endtask

    task automatic test_load;
        for (int a = 0; a < 1024; a++) begin
            ld_we   = 1'b1;
            ld_addr = AW'(a);
            ld_data = (a < 4) ? pat[a] : $urandom;
            step;
        end
        ld_we = 1'b0;
        step;
    endtask

    task automatic test_ce_low;
        for (int c = 0; c < 5; c++) begin
            settle;
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (valid_v[k] !== 1'b0) begin n_err++; $display("FAIL celow_valid k=%0d c=%0d got=%b exp=0", k, c, valid_v[k]); end
                n_cmp++; if (stall_v[k] !== 1'b0) begin n_err++; $display("FAIL celow_stall k=%0d c=%0d got=%b exp=0", k, c, stall_v[k]); end
                n_cmp++; if (inst_v[k] !== 32'h0) begin n_err++; $display("FAIL celow_inst k=%0d c=%0d got=%h exp=0", k, c, inst_v[k]); end
            end
            step;
        end
    endtask

    task automatic test_w0_stream;
        for (int i = 0; i < 6; i++) begin
            ce_v[0] = (i < 4);
            pc_v[0] = 32'(4 * i);
            settle;
            n_cmp++; if (stall_v[0] !== 1'b0) begin n_err++; $display("FAIL w0_stall i=%0d got=%b exp=0", i, stall_v[0]); end
            if (i >= 1 && i <= 4) begin
                n_cmp++; if (valid_v[0] !== 1'b1) begin n_err++; $display("FAIL w0_valid i=%0d got=%b exp=1", i, valid_v[0]); end
                n_cmp++; if (inst_v[0] !== pat[i-1]) begin n_err++; $display("FAIL w0_inst i=%0d got=%h exp=%h", i, inst_v[0], pat[i-1]); end
                n_cmp++; if (fault_v[0] !== 1'b0) begin n_err++; $display("FAIL w0_fault i=%0d got=%b exp=0", i, fault_v[0]); end
            end else if (i == 5) begin
                n_cmp++; if (valid_v[0] !== 1'b0) begin n_err++; $display("FAIL w0_tail_valid got=%b exp=0", valid_v[0]); end
            end
            step;
        end
    endtask

    task automatic test_w2_fetch;
        logic [2:0] exp_st;
        exp_st = 3'b011;
        for (int c = 0; c < 5; c++) begin
            ce_v[1] = (c < 2);
            pc_v[1] = (c == 0) ? 32'h8 : 32'h0;
            settle;
            if (c < 3) begin
                n_cmp++; if (stall_v[1] !== exp_st[c]) begin n_err++; $display("FAIL w2_stall c=%0d got=%b exp=%b", c, stall_v[1], exp_st[c]); end
                n_cmp++; if (valid_v[1] !== 1'b0) begin n_err++; $display("FAIL w2_early_valid c=%0d got=%b exp=0", c, valid_v[1]); end
            end else if (c == 3) begin
                n_cmp++; if (valid_v[1] !== 1'b1) begin n_err++; $display("FAIL w2_valid got=%b exp=1", valid_v[1]); end
                n_cmp++; if (inst_v[1] !== 32'h33333333) begin n_err++; $display("FAIL w2_inst got=%h exp=33333333", inst_v[1]); end
                n_cmp++; if (fault_v[1] !== 1'b0) begin n_err++; $display("FAIL w2_fault got=%b exp=0", fault_v[1]); end
            end else begin
                n_cmp++; if (valid_v[1] !== 1'b0) begin n_err++; $display("FAIL w2_tail_valid got=%b exp=0", valid_v[1]); end
            end
            step;
        end
    endtask

    task automatic test_faults;
        logic [31:0] fpc  [3];
        logic        fexp [3];
        logic [31:0] iexp [3];
        fpc  = '{32'h00000006, 32'h00001000, 32'h00000FFC};
        fexp = '{1'b1, 1'b1, 1'b0};
        iexp = '{32'h0, 32'h0, m_mem[1023]};
        for (int i = 0; i < 4; i++) begin
            ce_v[0] = (i < 3);
            pc_v[0] = (i < 3) ? fpc[i] : 32'h0;
            settle;
            if (i > 0) begin
                n_cmp++; if (valid_v[0] !== 1'b1) begin n_err++; $display("FAIL fault_valid pc=%h got=%b exp=1", fpc[i-1], valid_v[0]); end
                n_cmp++; if (fault_v[0] !== fexp[i-1]) begin n_err++; $display("FAIL fault_flag pc=%h got=%b exp=%b", fpc[i-1], fault_v[0], fexp[i-1]); end
                n_cmp++; if (inst_v[0] !== iexp[i-1]) begin n_err++; $display("FAIL fault_inst pc=%h got=%h exp=%h", fpc[i-1], inst_v[0], iexp[i-1]); end
            end
            step;
        end
    endtask

    task automatic test_collision;
        ce_v[0] = 1'b1;
        pc_v[0] = 32'h8;
        ld_we   = 1'b1;
        ld_addr = AW'(2);
        ld_data = 32'hDEADBEEF;
        step;
        ld_we = 1'b0;
        settle;
        n_cmp++; if (inst_v[0] !== 32'h33333333) begin n_err++; $display("FAIL collide_old got=%h exp=33333333", inst_v[0]); end
        step;
        ce_v[0] = 1'b0;
        settle;
        n_cmp++; if (inst_v[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL collide_new got=%h exp=deadbeef", inst_v[0]); end
        step;
    endtask

    task automatic test_reset_mid;
        ce_v[2] = 1'b1;
        pc_v[2] = 32'h4;
        settle;
        n_cmp++; if (stall_v[2] !== 1'b1) begin n_err++; $display("FAIL rmid_accept_stall got=%b exp=1", stall_v[2]); end
        step;
        ce_v[2] = 1'b0;
        settle;
        n_cmp++; if (stall_v[2] !== 1'b1) begin n_err++; $display("FAIL rmid_busy_stall got=%b exp=1", stall_v[2]); end
        step;
        rst = 1'b1;
        settle;
        n_cmp++; if (stall_v[2] !== 1'b0) begin n_err++; $display("FAIL rmid_rst_stall got=%b exp=0", stall_v[2]); end
        step;
        rst     = 1'b0;
        ce_v[2] = 1'b1;
        pc_v[2] = 32'h4;
        settle;
        n_cmp++; if (valid_v[2] !== 1'b0) begin n_err++; $display("FAIL rmid_valid got=%b exp=0", valid_v[2]); end
        n_cmp++; if (inst_v[2] !== 32'h0) begin n_err++; $display("FAIL rmid_inst got=%h exp=0", inst_v[2]); end
        n_cmp++; if (fault_v[2] !== 1'b0) begin n_err++; $display("FAIL rmid_fault got=%b exp=0", fault_v[2]); end
        step;
        ce_v[2] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            settle;
            if (c == 4) begin
                n_cmp++; if (valid_v[2] !== 1'b1) begin n_err++; $display("FAIL rmid_refetch_valid got=%b exp=1", valid_v[2]); end
                n_cmp++; if (inst_v[2] !== 32'h22222222) begin n_err++; $display("FAIL rmid_refetch_inst got=%h exp=22222222", inst_v[2]); end
            end else begin
                n_cmp++; if (valid_v[2] !== 1'b0) begin n_err++; $display("FAIL rmid_gap_valid c=%0d got=%b exp=0", c, valid_v[2]); end
            end
            step;
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                ce_v[k] = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 7))
                    0:       pc_v[k] = ($urandom_range(0, 1023) << 2) | $urandom_range(1, 3);
                    1:       pc_v[k] = $urandom | 32'h00001000;
                    default: pc_v[k] = $urandom_range(0, 1023) << 2;
                endcase
            end
            ld_we   = ($urandom_range(0, 3) == 0);
            ld_addr = AW'($urandom_range(0, 1023));
            ld_data = $urandom;
            settle;
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (stall_v[k] !== exp_stall(k)) begin n_err++; $display("FAIL rnd_stall k=%0d cyc=%0d got=%b exp=%b", k, cyc, stall_v[k], exp_stall(k)); end
                n_cmp++; if (valid_v[k] !== m_valid[k]) begin n_err++; $display("FAIL rnd_valid k=%0d cyc=%0d got=%b exp=%b", k, cyc, valid_v[k], m_valid[k]); end
                n_cmp++; if (fault_v[k] !== m_fault[k]) begin n_err++; $display("FAIL rnd_fault k=%0d cyc=%0d got=%b exp=%b", k, cyc, fault_v[k], m_fault[k]); end
                n_cmp++; if (inst_v[k] !== m_inst[k]) begin n_err++; $display("FAIL rnd_inst k=%0d cyc=%0d got=%h exp=%h", k, cyc, inst_v[k], m_inst[k]); end
            end
            step;
        end
        ld_we = 1'b0;
        for (int k = 0; k < 3; k++) ce_v[k] = 1'b0;
        step;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_load;
        test_ce_low;
        test_w0_stream;
        test_w2_fetch;
        test_faults;
        test_collision;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/inst_rom_resp.md
# inst_rom_resp

Responder end of the instruction-fetch interface: samples the fetch address `pc` and the fetch enable `ce` from the program counter stage and returns the addressed 32-bit instruction word. It holds a synchronous instruction memory with a loader write port and a configurable number of wait states. It back-pressures the requester with `stall` and flags misaligned or out-of-range fetches with `fault`. It sits between the PC stage and the IF/ID pipeline register.

## Interface
- `ADDR_WIDTH`, 10, word-address bits; memory depth = 2^ADDR_WIDTH words of 32 bits.
- `WAIT_STATES`, 0, extra cycles per fetch, legal range 0..7.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ce`  in  1  fetch request; high = `pc` is a valid fetch address this cycle.
- `pc`  in  32  byte address of the instruction to fetch.
- `stall`  out  1  combinational; high = requester must hold `pc` next cycle.
- `inst`  out  32  fetched instruction, registered.
- `inst_valid`  out  1  registered; one-cycle pulse per completed fetch.
- `fault`  out  1  registered; qualifies `inst_valid`, set for misaligned or out-of-range fetch.
- `ld_we`  in  1  loader write enable.
- `ld_addr`  in  ADDR_WIDTH  loader word address.
- `ld_data`  in  32  loader write data.

## Operation
- Address decode: word index = `pc[ADDR_WIDTH+1:2]`. Misaligned if `pc[1:0] != 0`. Out of range if `pc[31:ADDR_WIDTH+2] != 0`.
- Faulting fetch: `inst = 32'h00000000` (nop), `inst_valid = 1`, `fault = 1`. Same latency as a good fetch. The memory is not read.
- States:
  - IDLE: accepts a request when `ce = 1` and `rst = 0`.
    - `WAIT_STATES = 0`: stays in IDLE and registers the response at the edge.
    - `WAIT_STATES > 0`: latches `pc`, loads `cnt = WAIT_STATES`, and moves to BUSY.
  - BUSY: ignores `ce` and `pc` and uses the latched address. Decrements `cnt` each cycle. When `cnt = 1` it reads memory, registers the response, and returns to IDLE.
- `stall` = `(state == IDLE && ce && WAIT_STATES > 0) || (state == BUSY && cnt > 1)`. Forced to 0 while `rst = 1`.
- `ce` deasserting during BUSY does not cancel the fetch; the response is still delivered.
- Loader port: on `ld_we = 1`, `mem[ld_addr] <= ld_data` at the edge. Loader writes are accepted in any state.
- Read/write collision: a fetch reading the word being written in the same cycle returns the old data (read-before-write).
- Memory contents are not affected by `rst`. Contents are undefined until loaded.
- In any cycle with no completing fetch: `inst_valid = 0`, `fault = 0`, `inst = 0`.

## Timing
- Reset values: `inst = 0`, `inst_valid = 0`, `fault = 0`, state = IDLE, `cnt = 0`. `stall = 0` during reset.
- Reset mid-BUSY: the fetch is aborted, no `inst_valid` is produced, and the block is in IDLE the cycle after reset is released.
- Latency: a request accepted in cycle N gives `inst_valid` in cycle N+1+WAIT_STATES.
- Throughput: one fetch per WAIT_STATES+1 cycles. With `WAIT_STATES = 0`, back-to-back fetches complete every cycle.
- Example, W=2: accept A in cycle 0 (`stall = 1`). Cycle 1 BUSY with `cnt = 2` (`stall = 1`). Cycle 2 BUSY with `cnt = 1` (`stall = 0`). Cycle 3: `inst_valid` for A, and next `pc` accepted.
- A requester that ignores `stall` and changes `pc` during BUSY has its new address dropped. No error is flagged.
- Address arithmetic: no wrap. Any `pc` ≥ 4·2^ADDR_WIDTH faults.

## Test plan
- W=0: load words 0..3 with 0x11111111, 0x22222222, 0x33333333, 0x44444444; drive `ce = 1` with `pc` = 0, 4, 8, 12 on consecutive cycles → `inst_valid` every cycle from cycle 1, `inst` in load order, `stall` constant 0.
- W=2: fetch `pc = 8` (word = 0x33333333) → `stall = 1, 1, 0` in cycles 0–2, `inst_valid` with `inst = 0x33333333` in cycle 3. Change `pc` in cycle 1 → response is still 0x33333333.
- Faults, ADDR_WIDTH=10: `pc = 0x00000006` and `pc = 0x00001000` → `inst_valid = 1`, `fault = 1`, `inst = 0`. `pc = 0x00000FFC` → `fault = 0`.
- Collision, W=0: write 0xDEADBEEF to word 2 in the same cycle as fetching `pc = 8` (old word 0x33333333) → `inst = 0x33333333`. Refetch `pc = 8` → `inst = 0xDEADBEEF`.
- Reset mid-fetch, W=3: accept a fetch, assert `rst` in cycle 2 → no `inst_valid`, all outputs 0. A fetch in the first cycle after reset release completes 4 cycles later.
- `ce` low: hold `ce = 0` for 5 cycles in IDLE → `inst_valid = 0`, `stall = 0`, `inst = 0` throughout.
